// File: rtl/i_decode_if.sv
// Decode-stage bus: instruction and write-back data in, control signals,
// register operands and the extended immediate out.
// Optional feature macro: IDECODE_ILLEGAL_EN adds the illegal_instr flag.
interface i_decode_if #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32
);
  logic [INSTR_LEN-1:0] Instruction;
  logic [WORD-1:0]      write_data;
  logic                 uncond_branch;
  logic                 branch;
  logic                 mem_read;
  logic                 mem_to_reg;
  logic                 mem_write;
  logic                 ALU_src;
  logic [1:0]           ALU_op;
  logic [WORD-1:0]      read_data1;
  logic [WORD-1:0]      read_data2;
  logic [WORD-1:0]      sign_extended;
`ifdef IDECODE_ILLEGAL_EN
  logic                 illegal_instr;
`endif

  // Fetch / pipeline side: supplies the instruction and write-back value.
  modport master (
    output Instruction, write_data,
    input  uncond_branch, branch, mem_read, mem_to_reg, mem_write,
    input  ALU_src, ALU_op, read_data1, read_data2, sign_extended
`ifdef IDECODE_ILLEGAL_EN
    , input illegal_instr
`endif
  );

  // Decoder side.
  modport slave (
    input  Instruction, write_data,
    output uncond_branch, branch, mem_read, mem_to_reg, mem_write,
    output ALU_src, ALU_op, read_data1, read_data2, sign_extended
`ifdef IDECODE_ILLEGAL_EN
    , output illegal_instr
`endif
  );
endinterface

// File: rtl/i_decode.sv
// LEGv8 decode stage: opcode decode, 32x64 register file (X31 = XZR),
// immediate extension and write-back into Rd.
// Optional feature macro: IDECODE_ILLEGAL_EN drives illegal_instr high for
// opcodes outside the supported set (they still decode as NOP).
module i_decode #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic      read_clk,
  input  logic      reset,
  i_decode_if.slave bus
);

  localparam logic [4:0] REG_XZR = 5'd31;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_D,
    IMM_CB,
    IMM_B,
    IMM_ADDI
  } imm_sel_t;

  logic [10:0] opcode;
  logic [4:0]  rn, rm, rd, reg2;
  logic        reg_write, reg2loc;
  imm_sel_t    imm_sel;
  logic [WORD-1:0] regs_q [NUM_REGS];
`ifdef IDECODE_ILLEGAL_EN
  logic        illegal;
`endif

  assign opcode = bus.Instruction[31:21];
  assign rn     = bus.Instruction[9:5];
  assign rm     = bus.Instruction[20:16];
  assign rd     = bus.Instruction[4:0];

  // Opcode decode into control signals; anything unrecognised is a NOP.
  always_comb begin
    bus.uncond_branch = 1'b0;
    bus.branch        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ALU_src       = 1'b0;
    bus.ALU_op        = 2'b00;
    reg_write         = 1'b0;
    reg2loc           = 1'b0;
    imm_sel           = IMM_NONE;
`ifdef IDECODE_ILLEGAL_EN
    illegal           = 1'b0;
`endif
    casez (opcode)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: begin
        bus.ALU_op = 2'b10;
        reg_write  = 1'b1;
      end
      11'b11111000010: begin
        bus.mem_read   = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.ALU_src    = 1'b1;
        reg_write      = 1'b1;
        imm_sel        = IMM_D;
      end
      11'b11111000000: begin
        bus.mem_write = 1'b1;
        bus.ALU_src   = 1'b1;
        reg2loc       = 1'b1;
        imm_sel       = IMM_D;
      end
      11'b10110100???: begin
        bus.branch = 1'b1;
        bus.ALU_op = 2'b01;
        reg2loc    = 1'b1;
        imm_sel    = IMM_CB;
      end
      11'b000101?????: begin
        bus.uncond_branch = 1'b1;
        imm_sel           = IMM_B;
      end
      11'b1001000100?: begin
        bus.ALU_src = 1'b1;
        reg_write   = 1'b1;
        imm_sel     = IMM_ADDI;
      end
      default: begin
`ifdef IDECODE_ILLEGAL_EN
        illegal = 1'b1;
`endif
      end
    endcase
  end

`ifdef IDECODE_ILLEGAL_EN
  assign bus.illegal_instr = illegal;
`endif

  // Immediate field selection; ADDI's unsigned 12-bit field is zero-extended.
  always_comb begin
    bus.sign_extended = '0;
    case (imm_sel)
      IMM_D:    bus.sign_extended = {{(WORD-9){bus.Instruction[20]}},  bus.Instruction[20:12]};
      IMM_CB:   bus.sign_extended = {{(WORD-19){bus.Instruction[23]}}, bus.Instruction[23:5]};
      IMM_B:    bus.sign_extended = {{(WORD-26){bus.Instruction[25]}}, bus.Instruction[25:0]};
      IMM_ADDI: bus.sign_extended = {{(WORD-12){1'b0}},                bus.Instruction[21:10]};
      default:  bus.sign_extended = '0;
    endcase
  end

  // Combinational register reads; XZR always reads zero and there is no bypass.
  assign reg2           = reg2loc ? rd : rm;
  assign bus.read_data1 = (rn   == REG_XZR) ? '0 : regs_q[rn];
  assign bus.read_data2 = (reg2 == REG_XZR) ? '0 : regs_q[reg2];

  // Register file: reset preloads X[i]=i, then writes Rd on the rising edge.
  always_ff @(posedge read_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == NUM_REGS - 1) ? '0 : WORD'(i);
      end
    end else if (reg_write && (rd != REG_XZR)) begin
      regs_q[rd] <= bus.write_data;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Self-checking bench for i_decode: directed scenarios followed by randomized
// instruction streams compared against a behavioural decode/register model.
module tb_i_decode;

  logic read_clk = 1'b0;
  logic reset;

  i_decode_if bus ();

  i_decode dut (
    .read_clk (read_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 read_clk = ~read_clk;

  int checks   = 0;
  int failures = 0;
  longint unsigned model [32];

  typedef struct packed {
    logic [7:0]  ctrl;   // {ub, br, mr, m2r, mw, src, op[1:0]}
    logic        rw;
    logic        r2l;
    logic        ill;
    logic [63:0] imm;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    logic [10:0]       op;
    logic signed [8:0]  d9;
    logic signed [18:0] c19;
    logic signed [25:0] b26;
    longint             v;
    e   = '0;
    op  = ins[31:21];
    d9  = ins[20:12];
    c19 = ins[23:5];
    b26 = ins[25:0];
    if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) begin
      e.ctrl = 8'b0000_0010; e.rw = 1'b1;
    end else if (op == 11'h7C2) begin
      e.ctrl = 8'b0011_0100; e.rw = 1'b1; v = d9; e.imm = v;
    end else if (op == 11'h7C0) begin
      e.ctrl = 8'b0000_1100; e.r2l = 1'b1; v = d9; e.imm = v;
    end else if (op[10:3] == 8'hB4) begin
      e.ctrl = 8'b0100_0001; e.r2l = 1'b1; v = c19; e.imm = v;
    end else if (op[10:5] == 6'b000101) begin
      e.ctrl = 8'b1000_0000; v = b26; e.imm = v;
    end else if (op[10:1] == 10'b1001000100) begin
      e.ctrl = 8'b0000_0100; e.rw = 1'b1; e.imm = 64'(ins[21:10]);
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 31; i++) model[i] = longint'(i);
    model[31] = 0;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] wd);
    bus.Instruction = ins;
    bus.write_data  = wd;
    #2;
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    int   rn, r2;
    e  = ref_decode(bus.Instruction);
    rn = int'(bus.Instruction[9:5]);
    r2 = e.r2l ? int'(bus.Instruction[4:0]) : int'(bus.Instruction[20:16]);
    chk({tag, ".ctrl"}, 64'({bus.uncond_branch, bus.branch, bus.mem_read, bus.mem_to_reg,
                             bus.mem_write, bus.ALU_src, bus.ALU_op}), 64'(e.ctrl));
    chk({tag, ".imm"}, bus.sign_extended, e.imm);
    chk({tag, ".rd1"}, bus.read_data1, model[rn]);
    chk({tag, ".rd2"}, bus.read_data2, model[r2]);
`ifdef IDECODE_ILLEGAL_EN
    chk({tag, ".ill"}, 64'(bus.illegal_instr), 64'(e.ill));
`endif
  endtask

  task automatic tick();
    exp_t e;
    int   rd;
    e  = ref_decode(bus.Instruction);
    rd = int'(bus.Instruction[4:0]);
    @(posedge read_clk);
    if (e.rw && rd != 31 && reset) model[rd] = bus.write_data;
    #1;
  endtask

  function automatic logic [31:0] add_rr(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd);
    return {11'h458, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return {11'h458, r[20:0]};
      1: return {11'h658, r[20:0]};
      2: return {11'h450, r[20:0]};
      3: return {11'h550, r[20:0]};
      4: return {11'h7C2, r[20:0]};
      5: return {11'h7C0, r[20:0]};
      6: return {8'hB4, r[23:0]};
      7: return {6'b000101, r[25:0]};
      8: return {10'b1001000100, r[21:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    reset           = 1'b0;
    bus.Instruction = '0;
    bus.write_data  = '0;
    model_reset();
    repeat (2) @(posedge read_clk);
    #1;
    // Reset state: X[i]=i while reset is held.
    drive(add_rr(5'd9, 5'd30, 5'd31), 64'h0);
    chk("rst.x9", bus.read_data1, 64'd9);
    chk("rst.x30", bus.read_data2, 64'd30);
    @(posedge read_clk);
    #1;
    reset = 1'b1;

    // 1: ADD X3,X1,X2
    drive(32'h8B020023, 64'h0);
    chk("t1.rd1", bus.read_data1, 64'd1);
    chk("t1.rd2", bus.read_data2, 64'd2);
    chk("t1.aluop", 64'(bus.ALU_op), 64'd2);
    chk("t1.src", 64'(bus.ALU_src), 64'd0);
    check_outputs("t1");
    tick();

    // 2: LDUR X5,[X2,#-8] then read back X5
    drive(32'hF85F8045, 64'hDEAD);
    chk("t2.mr", 64'({bus.mem_read, bus.mem_to_reg, bus.ALU_src}), 64'b111);
    chk("t2.imm", bus.sign_extended, 64'hFFFF_FFFF_FFFF_FFF8);
    check_outputs("t2");
    tick();
    drive(add_rr(5'd5, 5'd0, 5'd31), 64'h0);
    chk("t2.x5", bus.read_data1, 64'hDEAD);
    tick();

    // 3: STUR X4,[X1,#16]
    drive(32'hF8010024, 64'h1234);
    chk("t3.mw", 64'(bus.mem_write), 64'd1);
    chk("t3.rd2", bus.read_data2, 64'd4);
    chk("t3.imm", bus.sign_extended, 64'd16);
    tick();
    drive(add_rr(5'd4, 5'd1, 5'd31), 64'h0);
    chk("t3.x4", bus.read_data1, 64'd4);
    chk("t3.x1", bus.read_data2, 64'd1);
    tick();

    // 4: CBZ X7,#-1 and B #3
    drive(32'hB4FFFFE7, 64'h0);
    chk("t4.br", 64'(bus.branch), 64'd1);
    chk("t4.aluop", 64'(bus.ALU_op), 64'd1);
    chk("t4.rd2", bus.read_data2, 64'd7);
    chk("t4.imm", bus.sign_extended, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    drive(32'h14000003, 64'h0);
    chk("t4.ub", 64'(bus.uncond_branch), 64'd1);
    chk("t4.bimm", bus.sign_extended, 64'd3);
    tick();

    // 5: write to XZR is discarded; reset mid-run restores X5
    drive({10'b1001000100, 12'd1, 5'd0, 5'd31}, 64'h55);
    tick();
    drive(add_rr(5'd31, 5'd31, 5'd31), 64'h0);
    chk("t5.xzr1", bus.read_data1, 64'd0);
    chk("t5.xzr2", bus.read_data2, 64'd0);
    drive(add_rr(5'd5, 5'd5, 5'd5), 64'hBEEF);
    chk("t5.pre", bus.read_data1, 64'hDEAD);
    #1;
    reset = 1'b0;
    #1;
    chk("t5.rst", bus.read_data1, 64'd5);
    model_reset();
    @(posedge read_clk);
    #1;
    chk("t5.blk", bus.read_data1, 64'd5);
    reset = 1'b1;

    // 6: all-zero instruction is a NOP and writes nothing
    drive(32'h0, 64'hFFFF);
    chk("t6.ctrl", 64'({bus.uncond_branch, bus.branch, bus.mem_read, bus.mem_to_reg,
                        bus.mem_write, bus.ALU_src, bus.ALU_op}), 64'd0);
`ifdef IDECODE_ILLEGAL_EN
    chk("t6.ill", 64'(bus.illegal_instr), 64'd1);
`endif
    tick();
    drive(add_rr(5'd0, 5'd0, 5'd31), 64'h0);
    chk("t6.x0", bus.read_data1, 64'd0);
    tick();

    // Randomized stream with occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      drive(rand_instr(), {$urandom, $urandom});
      check_outputs("rnd");
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("rnd.rst");
        tick();
        check_outputs("rnd.hold");
        reset = 1'b1;
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
